// File: rtl/input_conditioner_if.sv
// Pin-side bundle for the input conditioner.
// Raw inputs in; debounced level and edge pulses out.
interface input_conditioner_if #(
    parameter int CHANNELS = 3
);
    logic [CHANNELS-1:0] d;
    logic [CHANNELS-1:0] q;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;

    modport master (
        output d,
        input  q,
        input  rise,
        input  fall
    );

    modport slave (
        input  d,
        output q,
        output rise,
        output fall
    );
endinterface

// File: rtl/input_conditioner.sv
// Per-channel synchroniser plus debounce counter for async pins.
// Emits a registered clean level and one-cycle rise/fall pulses.
module input_conditioner #(
    parameter int CHANNELS        = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic clk,
    input logic reset,
    input_conditioner_if.slave io
);

    localparam int CNT_W =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX =
        CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0] q_v;
    logic [CHANNELS-1:0] rise_v;
    logic [CHANNELS-1:0] fall_v;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] s;
        logic [CNT_W-1:0]       cnt;
        logic                   sync;
        logic                   q_c;
        logic                   rise_c;
        logic                   fall_c;

        assign sync = s[SYNC_STAGES-1];

        always_ff @(posedge clk) begin
            if (reset) begin
                s      <= '0;
                cnt    <= '0;
                q_c    <= 1'b0;
                rise_c <= 1'b0;
                fall_c <= 1'b0;
            end else begin
                s      <= {s[SYNC_STAGES-2:0], io.d[c]};
                rise_c <= 1'b0;
                fall_c <= 1'b0;
                // Any agreement with q restarts the stability window.
                if (sync == q_c) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    q_c    <= sync;
                    cnt    <= '0;
                    rise_c <= sync;
                    fall_c <= ~sync;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign q_v[c]    = q_c;
        assign rise_v[c] = rise_c;
        assign fall_v[c] = fall_c;
    end

    assign io.q    = q_v;
    assign io.rise = rise_v;
    assign io.fall = fall_v;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner.
// Second instance runs with a single-cycle debounce window.
module tb_input_conditioner;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [2:0] acc;
    logic [2:0] pat;
    logic [2:0] vec [10];
    logic [2:0] exp_q;
    logic [2:0] prev_q;

    input_conditioner_if #(.CHANNELS(3)) ifc ();
    input_conditioner_if #(.CHANNELS(3)) ifc1 ();

    input_conditioner #(
        .CHANNELS(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
    ) u_dut (
        .clk(clk), .reset(reset), .io(ifc)
    );

    input_conditioner #(
        .CHANNELS(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)
    ) u_dut1 (
        .clk(clk), .reset(reset), .io(ifc1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [2:0] obs,
                       input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        ifc.d  = 3'b111;
        ifc1.d = 3'b000;
        reset  = 1'b1;

        // 1: reset with inputs held high
        tick();
        chk("rst_q", ifc.q, 3'b000);
        chk("rst_rise", ifc.rise, 3'b000);
        chk("rst_fall", ifc.fall, 3'b000);
        chk("rst_q1", ifc1.q, 3'b000);
        tick();
        chk("rst_q_2", ifc.q, 3'b000);
        reset = 1'b0;
        repeat (5) tick();
        chk("rel_q_early", ifc.q, 3'b000);
        tick();
        chk("rel_q", ifc.q, 3'b111);
        chk("rel_rise", ifc.rise, 3'b111);
        tick();
        chk("rel_rise_end", ifc.rise, 3'b000);
        ifc.d = 3'b000;
        repeat (5) tick();
        chk("rel_fall_early", ifc.fall, 3'b000);
        tick();
        chk("rel_fall", ifc.fall, 3'b111);
        chk("rel_fall_q", ifc.q, 3'b000);
        tick();
        chk("rel_fall_end", ifc.fall, 3'b000);

        // 2: clean edge on channel 0
        ifc.d = 3'b001;
        repeat (5) tick();
        chk("clean_q_early", ifc.q, 3'b000);
        chk("clean_rise_early", ifc.rise, 3'b000);
        tick();
        chk("clean_q", ifc.q, 3'b001);
        chk("clean_rise", ifc.rise, 3'b001);
        tick();
        chk("clean_rise_end", ifc.rise, 3'b000);
        ifc.d = 3'b000;
        repeat (5) tick();
        chk("clean_fall_early", ifc.fall, 3'b000);
        tick();
        chk("clean_fall", ifc.fall, 3'b001);
        tick();
        chk("clean_fall_end", ifc.fall, 3'b000);
        chk("clean_q_low", ifc.q, 3'b000);

        // 3a: 3-cycle glitch on channel 1 is rejected
        acc   = 3'b000;
        ifc.d = 3'b010;
        repeat (3) begin
            tick();
            acc = acc | ifc.rise | ifc.fall | ifc.q;
        end
        ifc.d = 3'b000;
        repeat (8) begin
            tick();
            acc = acc | ifc.rise | ifc.fall | ifc.q;
        end
        chk("glitch3_none", acc, 3'b000);

        // 3b: 4-cycle pulse on channel 1 is accepted
        ifc.d = 3'b010;
        repeat (4) tick();
        ifc.d = 3'b000;
        tick();
        chk("glitch4_q_early", ifc.q, 3'b000);
        tick();
        chk("glitch4_rise", ifc.rise, 3'b010);
        chk("glitch4_q", ifc.q, 3'b010);
        repeat (3) tick();
        chk("glitch4_q_hold", ifc.q, 3'b010);
        chk("glitch4_fall_early", ifc.fall, 3'b000);
        tick();
        chk("glitch4_fall", ifc.fall, 3'b010);
        chk("glitch4_q_low", ifc.q, 3'b000);
        repeat (4) tick();

        // 4: bounce on channel 2, single rise from last stable edge
        acc = 3'b000;
        pat = 3'b000;
        for (int i = 0; i < 5; i++) begin
            pat[2] = ~i[0];
            ifc.d  = pat;
            tick();
            acc = acc | ifc.rise | ifc.fall;
        end
        repeat (4) begin
            tick();
            acc = acc | ifc.rise | ifc.fall;
        end
        chk("bounce_quiet", acc, 3'b000);
        chk("bounce_q_early", ifc.q, 3'b000);
        tick();
        chk("bounce_rise", ifc.rise, 3'b100);
        chk("bounce_q", ifc.q, 3'b100);
        acc = 3'b000;
        repeat (6) begin
            tick();
            acc = acc | ifc.rise | ifc.fall;
        end
        chk("bounce_no_more", acc, 3'b000);
        ifc.d = 3'b000;
        repeat (8) tick();
        chk("bounce_q_low", ifc.q, 3'b000);

        // 5: simultaneous channels
        ifc.d = 3'b101;
        repeat (5) tick();
        tick();
        chk("simul_rise", ifc.rise, 3'b101);
        chk("simul_q", ifc.q, 3'b101);
        ifc.d = 3'b000;
        repeat (5) tick();
        tick();
        chk("simul_fall", ifc.fall, 3'b101);
        repeat (2) tick();

        // 6: reset mid-count
        ifc.d = 3'b001;
        tick();
        tick();
        reset = 1'b1;
        acc   = 3'b000;
        tick();
        acc = acc | ifc.rise | ifc.fall | ifc.q;
        tick();
        acc = acc | ifc.rise | ifc.fall | ifc.q;
        chk("midrst_quiet", acc, 3'b000);
        reset = 1'b0;
        acc   = 3'b000;
        repeat (5) begin
            tick();
            acc = acc | ifc.rise | ifc.fall | ifc.q;
        end
        chk("midrst_restart", acc, 3'b000);
        tick();
        chk("midrst_rise", ifc.rise, 3'b001);
        chk("midrst_q", ifc.q, 3'b001);

        // 6b: single-cycle window tracks d two edges late
        vec[0] = 3'b101;
        vec[1] = 3'b011;
        vec[2] = 3'b011;
        vec[3] = 3'b000;
        vec[4] = 3'b111;
        vec[5] = 3'b010;
        vec[6] = 3'b010;
        vec[7] = 3'b000;
        vec[8] = 3'b000;
        vec[9] = 3'b000;
        prev_q = 3'b000;
        for (int i = 0; i < 10; i++) begin
            ifc1.d = vec[i];
            tick();
            exp_q = (i >= 2) ? vec[i-2] : 3'b000;
            chk($sformatf("dc1_q_%0d", i), ifc1.q, exp_q);
            chk($sformatf("dc1_rise_%0d", i), ifc1.rise,
                exp_q & ~prev_q);
            chk($sformatf("dc1_fall_%0d", i), ifc1.fall,
                ~exp_q & prev_q);
            prev_q = exp_q;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
